// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the century clock set-mode controller: state codes,
// field indices and the HEX digit groups owned by each field in each view.
package clock_ctrl_pkg;

  localparam logic [2:0] ST_RUN  = 3'd0;
  localparam logic [2:0] ST_SEC  = 3'd1;
  localparam logic [2:0] ST_MIN  = 3'd2;
  localparam logic [2:0] ST_HOUR = 3'd3;
  localparam logic [2:0] ST_DAY  = 3'd4;
  localparam logic [2:0] ST_MON  = 3'd5;
  localparam logic [2:0] ST_YEAR = 3'd6;

  typedef enum logic [2:0] {
    RUN    = ST_RUN,
    S_SEC  = ST_SEC,
    S_MIN  = ST_MIN,
    S_HOUR = ST_HOUR,
    S_DAY  = ST_DAY,
    S_MON  = ST_MON,
    S_YEAR = ST_YEAR
  } state_t;

  localparam int FLD_SEC   = 0;
  localparam int FLD_MIN   = 1;
  localparam int FLD_HOUR  = 2;
  localparam int FLD_DAY   = 3;
  localparam int FLD_MONTH = 4;
  localparam int FLD_YEAR  = 5;

  localparam logic [7:0] TIME_SEC_MASK   = 8'b0000_0011;
  localparam logic [7:0] TIME_MIN_MASK   = 8'b0000_1100;
  localparam logic [7:0] TIME_HOUR_MASK  = 8'b0011_0000;
  localparam logic [7:0] DATE_DAY_MASK   = 8'b1100_0000;
  localparam logic [7:0] DATE_MONTH_MASK = 8'b0011_0000;
  localparam logic [7:0] DATE_YEAR_MASK  = 8'b0000_1111;

  function automatic logic [5:0] field_onehot(input state_t s);
    logic [5:0] oh;
    oh = '0;
    case (s)
      S_SEC:   oh[FLD_SEC]   = 1'b1;
      S_MIN:   oh[FLD_MIN]   = 1'b1;
      S_HOUR:  oh[FLD_HOUR]  = 1'b1;
      S_DAY:   oh[FLD_DAY]   = 1'b1;
      S_MON:   oh[FLD_MONTH] = 1'b1;
      S_YEAR:  oh[FLD_YEAR]  = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

  // Digits that blink: only those of the selected field, and only if visible in this view.
  function automatic logic [7:0] blink_mask(input state_t s, input logic time_view);
    logic [7:0] m;
    m = '0;
    case (s)
      S_SEC:   m = time_view ? TIME_SEC_MASK   : 8'h00;
      S_MIN:   m = time_view ? TIME_MIN_MASK   : 8'h00;
      S_HOUR:  m = time_view ? TIME_HOUR_MASK  : 8'h00;
      S_DAY:   m = time_view ? 8'h00 : DATE_DAY_MASK;
      S_MON:   m = time_view ? 8'h00 : DATE_MONTH_MASK;
      S_YEAR:  m = time_view ? 8'h00 : DATE_YEAR_MASK;
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic state_t next_field(input state_t s);
    state_t n;
    case (s)
      S_SEC:   n = S_MIN;
      S_MIN:   n = S_HOUR;
      S_HOUR:  n = S_DAY;
      S_DAY:   n = S_MON;
      S_MON:   n = S_YEAR;
      default: n = S_SEC;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered copy of a debounced button level; press is high for one cycle
// on the first cycle the level is seen high.
module btn_edge (
  input  logic clk,
  input  logic rstn,
  input  logic level,
  output logic press
);

  logic prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) prev <= 1'b0;
    else       prev <= level;
  end

  assign press = level & ~prev;

endmodule

// File: rtl/clock_set_controller.sv
// Set-mode sequencer for the century clock: field selection FSM, sticky inc/dec
// requests consumed at the 1 s tick, idle timeout and per-digit blink enables.
module clock_set_controller
  import clock_ctrl_pkg::*;
#(
  parameter int BLINK_HALF = 12_499_999,
  parameter int TIMEOUT_S  = 10
) (
  input  logic       CLOCK_50,
  input  logic       rstn,
  input  logic       set_enable,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       tick_1s,
  input  logic       display,
  output logic [5:0] field_sel,
  output logic       inc_req,
  output logic       dec_req,
  output logic       run_en,
  output logic       set_active,
  output logic [7:0] hex_on
);

  localparam int BW = (BLINK_HALF > 0) ? $clog2(BLINK_HALF + 1) : 1;
  localparam int TW = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S + 1) : 1;
  localparam logic [BW-1:0] BLINK_MAX    = BW'(BLINK_HALF);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_S - 1);

  state_t        state, state_nxt;
  logic          mode_p, inc_p, dec_p, any_p;
  logic          inc_nxt, dec_nxt;
  logic [TW-1:0] idle_cnt, idle_nxt;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic          display_q;
  logic          timeout_hit;

  btn_edge u_mode (.clk(CLOCK_50), .rstn(rstn), .level(btn_mode), .press(mode_p));
  btn_edge u_inc  (.clk(CLOCK_50), .rstn(rstn), .level(btn_inc),  .press(inc_p));
  btn_edge u_dec  (.clk(CLOCK_50), .rstn(rstn), .level(btn_dec),  .press(dec_p));

  assign any_p       = mode_p | inc_p | dec_p;
  assign timeout_hit = tick_1s && !any_p && (idle_cnt == TIMEOUT_LAST);

  // A press in the tick cycle is evaluated ahead of the tick clear, so it survives.
  always_comb begin
    state_nxt = state;
    inc_nxt   = inc_req;
    dec_nxt   = dec_req;
    idle_nxt  = idle_cnt;
    if (!set_enable) begin
      state_nxt = RUN;
      inc_nxt   = 1'b0;
      dec_nxt   = 1'b0;
      idle_nxt  = '0;
    end else if (state == RUN) begin
      inc_nxt  = 1'b0;
      dec_nxt  = 1'b0;
      idle_nxt = '0;
      if (mode_p) state_nxt = S_SEC;
    end else if (mode_p) begin
      state_nxt = next_field(state);
      inc_nxt   = 1'b0;
      dec_nxt   = 1'b0;
      idle_nxt  = '0;
    end else if (timeout_hit) begin
      state_nxt = RUN;
      inc_nxt   = 1'b0;
      dec_nxt   = 1'b0;
      idle_nxt  = '0;
    end else begin
      if (any_p)        idle_nxt = '0;
      else if (tick_1s) idle_nxt = idle_cnt + TW'(1);
      if (inc_p && dec_p) begin
        inc_nxt = 1'b0;
        dec_nxt = 1'b0;
      end else if (inc_p) begin
        inc_nxt = 1'b1;
        dec_nxt = 1'b0;
      end else if (dec_p) begin
        inc_nxt = 1'b0;
        dec_nxt = 1'b1;
      end else if (tick_1s) begin
        inc_nxt = 1'b0;
        dec_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rstn) begin
    if (!rstn) begin
      state    <= RUN;
      inc_req  <= 1'b0;
      dec_req  <= 1'b0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      inc_req  <= inc_nxt;
      dec_req  <= dec_nxt;
      idle_cnt <= idle_nxt;
    end
  end

  // Every field change restarts the blink lit, so the new field is visible at once.
  always_ff @(posedge CLOCK_50 or negedge rstn) begin
    if (!rstn) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
      display_q <= 1'b1;
    end else begin
      display_q <= display;
      if (state_nxt != state || state == RUN) begin
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (blink_cnt == BLINK_MAX) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign field_sel  = field_onehot(state);
  assign run_en     = (state == RUN);
  assign set_active = (state != RUN);
  assign hex_on     = phase ? 8'hFF : ~blink_mask(state, display_q);

endmodule

// File: doc/clock_set_controller.md
# clock_set_controller

Sequencing controller for the century clock's time/date counters. It replaces ad-hoc set-mode logic with a clocked FSM that:
- selects which field (sec, min, hour, day, month, year) is being adjusted;
- turns debounced inc/dec presses into requests applied on the next 1 s tick;
- gates seconds counting while setting;
- drives per-digit blink enables for the eight HEX displays.

It sits between the debounce instances and the counter chain.

## Interface
Parameters:
- BLINK_HALF, 12_499_999: CLOCK_50 cycles per blink half-period minus one (2 Hz blink).
- TIMEOUT_S, 10: tick_1s pulses without any button press before auto-exit to RUN.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- rstn  in  1  reset, asynchronous, active-low.
- set_enable  in  1  level; 0 forces RUN.
- btn_mode  in  1  debounced level, active-high.
- btn_inc  in  1  debounced level, active-high.
- btn_dec  in  1  debounced level, active-high.
- tick_1s  in  1  one-CLOCK_50-cycle pulse per second.
- display  in  1  1 = time view, 0 = date view.
- field_sel  out  6  one-hot [0]=sec [1]=min [2]=hour [3]=day [4]=month [5]=year; all zero in RUN.
- inc_req  out  1  sticky increment request for the selected field.
- dec_req  out  1  sticky decrement request for the selected field.
- run_en  out  1  1 in RUN (seconds advance); 0 while setting.
- set_active  out  1  state != RUN.
- hex_on  out  8  per-digit visibility, 1 = lit.

## Operation
- Edge detection: one registered copy per button; press = level & ~prev.
- FSM states: RUN, S_SEC, S_MIN, S_HOUR, S_DAY, S_MON, S_YEAR.
- Transitions:
  - RUN → S_SEC on a mode press while set_enable=1.
  - S_SEC → S_MIN → S_HOUR → S_DAY → S_MON → S_YEAR → S_SEC on each mode press.
  - Any state → RUN when set_enable=0; this has priority over everything.
  - Any S_* state → RUN after TIMEOUT_S consecutive ticks with no press on any button. The timeout counter clears on every press and on entry to any S_* state.
- Requests (S_* states only; presses in RUN are ignored):
  - inc press sets inc_req and clears dec_req; dec press does the reverse.
  - inc and dec pressed in the same cycle: both requests cleared.
  - A mode press or an exit to RUN clears both requests.
  - Requests clear in the cycle after tick_1s=1 (the counters sample them at the tick).
  - A press coinciding with tick_1s wins: the request is set, not cleared.
- Blink:
  - The phase counter runs only in S_* states and counts 0..BLINK_HALF, toggling phase at wrap.
  - Phase = 1 (lit) on reset and on every state change.
- Digit mapping:
  - Time view: sec = HEX1:0, min = HEX3:2, hour = HEX5:4.
  - Date view: year = HEX3:0, month = HEX5:4, day = HEX7:6.
- hex_on: digits of the selected field follow the phase when that field is shown in the current view. All other digits are 1. In RUN, all 8'hFF.

## Timing
- Reset values: state RUN, field_sel 0, inc_req 0, dec_req 0, run_en 1, set_active 0, hex_on 8'hFF, phase 1, all counters 0.
- All outputs are registered or decoded from registered state; no input-to-output combinational path.
- Latency: a button that is high for the first time in cycle n gives state/request outputs updated at the clock edge ending cycle n (visible in cycle n+1).
- A held button produces exactly one press; a new press needs the input low for ≥1 cycle.
- set_enable falling: RUN and requests cleared on the next edge.
- rstn asserted mid-adjust: immediate return to reset values; no request is left pending.

## Structure
- Shared package clock_ctrl_pkg holds:
  - state encoding localparams;
  - field index constants FLD_SEC..FLD_YEAR;
  - HEX digit masks per field and view (e.g. TIME_MIN_MASK = 8'b0000_1100, DATE_YEAR_MASK = 8'b0000_1111).
- One sub-module, btn_edge (register plus rising-edge pulse), instantiated three times.
- FSM, request latches, timeout counter and blink counter stay in the top module.

## Test plan
- Reset, then set_enable=1 and one mode press → field_sel=6'b000001, run_en=0, hex_on[1:0] toggles every BLINK_HALF+1 cycles (shrink BLINK_HALF to 7 in the bench).
- Seven mode presses → field_sel walks sec..year, then back to 6'b000001; display=1 while on year → hex_on=8'hFF.
- In S_MIN: inc press → inc_req=1; dec press before the tick → inc_req=0, dec_req=1; tick_1s → dec_req=0 one cycle after the tick.
- inc and dec rising in the same cycle → both requests 0; press coinciding with tick_1s → request stays 1.
- TIMEOUT_S=3 with no presses over 3 ticks → RUN, field_sel=0, hex_on=8'hFF; a press at tick 2 restarts the count.
- rstn low during S_DAY with inc_req=1 → all outputs at reset values immediately; set_enable dropping in S_YEAR → RUN next cycle.
